// File: rtl/counter_monitor.sv
// counter_monitor: shadow model of the 8-bit up/down counter. Predicts the
// counter value each cycle, compares it against the observed bus, and keeps
// saturating check/error counts plus a capture of the first mismatch.
module counter_monitor #(
  parameter int WIDTH       = 8,
  parameter int ERR_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             start,
  input  logic             clear,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] chk_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic             active,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, HALT = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] pred_base;
  logic [WIDTH-1:0] pred;
  logic             miscmp;
  logic             err_sat;
  logic             chk_sat;

  // Prediction: seeded from the observed bus when arming, otherwise
  // free-running from our own estimate (never resyncs to cnt_in).
  always_comb begin
    pred_base = (state == IDLE) ? cnt_in : exp_q;
    if (dut_reset)
      pred = '0;
    else if (enable)
      pred = up_down ? pred_base + WIDTH'(1) : pred_base - WIDTH'(1);
    else
      pred = pred_base;
  end

  assign miscmp  = (state == CHECK) && (cnt_in != exp_q);
  assign err_sat = &err_count;
  assign chk_sat = &chk_count;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides everything else
  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = CHECK;
        CHECK:   if (STOP_ON_ERR && miscmp) state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: prediction, statistics and first-mismatch capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q     <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else if (clear) begin
      exp_q     <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      mismatch <= miscmp;
      case (state)
        IDLE: if (start) exp_q <= pred;
        CHECK: begin
          exp_q <= pred;
          if (!chk_sat) chk_count <= chk_count + ERR_W'(1);
          if (miscmp) begin
            if (!err_sat) err_count <= err_count + ERR_W'(1);
            if (err_count == '0) begin
              first_exp <= exp_q;
              first_got <= cnt_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    active = (state == CHECK);
    pass   = ((state == CHECK) || (state == HALT)) &&
             (chk_count != '0) && (err_count == '0);
  end

  assign expected = exp_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a golden up/down counter drives cnt_in (with
// optional one-cycle fault injection); three monitors (free-running,
// stop-on-error, narrow counters for saturation) are checked every cycle
// against a behavioural model.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dut_reset = 1'b0, enable = 1'b0, up_down = 1'b0;
  logic       start = 1'b0, clear = 1'b0;
  logic [7:0] cnt_in = 8'h00;

  logic [7:0]  exp_o [3];
  logic        mis_o [3];
  logic [15:0] err_o [3];
  logic [15:0] chk_o [3];
  logic [7:0]  fe_o  [3];
  logic [7:0]  fg_o  [3];
  logic        act_o [3];
  logic        pass_o[3];
  logic [3:0]  err2, chk2;

  int n_chk = 0, n_err = 0;

  // model state per instance
  int m_exp[3], m_err[3], m_chk[3], m_fe[3], m_fg[3];
  bit m_mis[3], m_on[3], m_halt[3];
  int smax[3] = '{65535, 65535, 15};
  bit stop[3] = '{1'b0, 1'b1, 1'b0};

  int g_cnt = 0;
  bit force_en = 1'b0;
  int force_val = 0;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(8), .ERR_W(16), .STOP_ON_ERR(1'b0)) u0 (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
    .up_down(up_down), .cnt_in(cnt_in), .start(start), .clear(clear),
    .expected(exp_o[0]), .mismatch(mis_o[0]), .err_count(err_o[0]),
    .chk_count(chk_o[0]), .first_exp(fe_o[0]), .first_got(fg_o[0]),
    .active(act_o[0]), .pass(pass_o[0]));

  counter_monitor #(.WIDTH(8), .ERR_W(16), .STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
    .up_down(up_down), .cnt_in(cnt_in), .start(start), .clear(clear),
    .expected(exp_o[1]), .mismatch(mis_o[1]), .err_count(err_o[1]),
    .chk_count(chk_o[1]), .first_exp(fe_o[1]), .first_got(fg_o[1]),
    .active(act_o[1]), .pass(pass_o[1]));

  counter_monitor #(.WIDTH(8), .ERR_W(4), .STOP_ON_ERR(1'b0)) u2 (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
    .up_down(up_down), .cnt_in(cnt_in), .start(start), .clear(clear),
    .expected(exp_o[2]), .mismatch(mis_o[2]), .err_count(err2),
    .chk_count(chk2), .first_exp(fe_o[2]), .first_got(fg_o[2]),
    .active(act_o[2]), .pass(pass_o[2]));

  assign err_o[2] = {12'h000, err2};
  assign chk_o[2] = {12'h000, chk2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int nxt(input int v);
    if (dut_reset) return 0;
    if (enable) return up_down ? (v + 1) % 256 : (v + 255) % 256;
    return v;
  endfunction

  function automatic void model_zero(input int i);
    m_exp[i] = 0; m_err[i] = 0; m_chk[i] = 0; m_fe[i] = 0; m_fg[i] = 0;
    m_mis[i] = 0; m_on[i] = 0; m_halt[i] = 0;
  endfunction

  function automatic void model_edge(input int i, input int c);
    if (clear) begin
      model_zero(i);
    end else if (m_on[i]) begin
      m_mis[i] = (c != m_exp[i]);
      if (m_chk[i] < smax[i]) m_chk[i]++;
      if (m_mis[i]) begin
        if (m_err[i] == 0) begin m_fe[i] = m_exp[i]; m_fg[i] = c; end
        if (m_err[i] < smax[i]) m_err[i]++;
        if (stop[i]) begin m_on[i] = 0; m_halt[i] = 1; end
      end
      m_exp[i] = nxt(m_exp[i]);
    end else if (m_halt[i]) begin
      m_mis[i] = 0;
    end else begin
      m_mis[i] = 0;
      if (start) begin m_exp[i] = nxt(c); m_on[i] = 1; end
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("expected%0d", i), exp_o[i], m_exp[i]);
      chk($sformatf("mismatch%0d", i), mis_o[i], m_mis[i]);
      chk($sformatf("err_count%0d", i), err_o[i], m_err[i]);
      chk($sformatf("chk_count%0d", i), chk_o[i], m_chk[i]);
      chk($sformatf("first_exp%0d", i), fe_o[i], m_fe[i]);
      chk($sformatf("first_got%0d", i), fg_o[i], m_fg[i]);
      chk($sformatf("active%0d", i), act_o[i], m_on[i]);
      chk($sformatf("pass%0d", i), pass_o[i],
          (m_on[i] || m_halt[i]) && m_chk[i] != 0 && m_err[i] == 0);
    end
  endtask

  // one clock: inputs already set by caller; pulses drop afterwards
  task automatic step();
    int c;
    cnt_in = force_en ? force_val[7:0] : g_cnt[7:0];
    @(posedge clk);
    c = int'(cnt_in);
    for (int i = 0; i < 3; i++) model_edge(i, c);
    g_cnt = nxt(g_cnt);
    #1;
    compare_all();
    start = 0; clear = 0; dut_reset = 0; force_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) model_zero(i);
    #1;
    compare_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    compare_all();
  endtask

  initial begin
    do_reset();
    chk("rst_active", act_o[0], 0);
    chk("rst_pass", pass_o[0], 0);

    // count up 300 edges through the 0xFF->0x00 wrap
    enable = 1; up_down = 1; start = 1;
    step();
    repeat (300) step();
    chk("up_chk300", chk_o[0], 300);
    chk("up_err0", err_o[0], 0);
    chk("up_pass", pass_o[0], 1);

    // count down from 0x00
    clear = 1; dut_reset = 1; step();
    enable = 1; up_down = 0; start = 1; step();
    repeat (9) step();
    chk("down_F6", exp_o[0], 8'hF6);
    chk("down_err0", err_o[0], 0);

    // enable low and dut_reset at 0x2A
    clear = 1; dut_reset = 1; step();
    enable = 1; up_down = 1; start = 1; step();
    repeat (41) step();
    chk("hold_2A_pre", exp_o[0], 8'h2A);
    enable = 0;
    repeat (5) step();
    chk("hold_2A", exp_o[0], 8'h2A);
    dut_reset = 1; step();
    chk("dutrst_0", exp_o[0], 0);
    chk("dutrst_nomis", mis_o[0], 0);

    // injected fault: 0x13 observed while 0x12 expected
    enable = 1; up_down = 1;
    repeat (18) step();
    chk("pre_fault_12", exp_o[0], 8'h12);
    enable = 0; force_en = 1; force_val = 8'h13; step();
    chk("fault_mis", mis_o[0], 1);
    chk("fault_err1", err_o[0], 1);
    chk("fault_fexp", fe_o[0], 8'h12);
    chk("fault_fgot", fg_o[0], 8'h13);
    chk("fault_halt", act_o[1], 0);
    begin
      logic [15:0] frz;
      frz = chk_o[1];
      enable = 1;
      repeat (5) step();
      chk("halt_frozen", chk_o[1], frz);
      chk("halt_err1", err_o[1], 1);
      chk("cont_active", act_o[0], 1);
      chk("cont_err1", err_o[0], 1);
    end

    // clear beats start; start one cycle later re-arms
    clear = 1; start = 1; step();
    chk("clr_active", act_o[0], 0);
    chk("clr_err", err_o[0], 0);
    chk("clr_chk", chk_o[0], 0);
    start = 1; step();
    chk("rearm_active", act_o[0], 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 500 == 0) do_reset();
      enable    = ($urandom % 4) != 0;
      up_down   = $urandom % 2;
      dut_reset = ($urandom % 40) == 0;
      start     = ($urandom % 20) == 0;
      clear     = ($urandom % 150) == 0;
      force_en  = ($urandom % 30) == 0;
      force_val = $urandom % 256;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Hardware checker that sits on the output side of the 8-bit up/down `counter`. It observes the counter's control inputs and its `out` bus and predicts the value that `out` must hold on every cycle. It flags, counts and captures mismatches. It is instantiated next to `counter` in self-checking builds and supplies the pass/fail status to the top level.

## Interface
- `WIDTH`, 8, width of the observed counter value.
- `ERR_W`, 16, width of the error and check counters; both saturate.
- `STOP_ON_ERR`, 0, 1 = freeze checking after the first mismatch.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `dut_reset` input 1: the counter's own reset (active-high, synchronous), as seen at the counter.
- `enable` input 1: the counter's enable, as seen at the counter.
- `up_down` input 1: the counter's direction (1 = up, 0 = down).
- `cnt_in` input WIDTH: the counter's `out`.
- `start` input 1: one-cycle pulse; arms the checker.
- `clear` input 1: synchronous; returns the block to IDLE and zeroes all statistics.
- `expected` output WIDTH: current predicted counter value (`exp_q`).
- `mismatch` output 1: registered one-cycle pulse per failed comparison.
- `err_count` output ERR_W: number of mismatches since the last clear; saturating.
- `chk_count` output ERR_W: number of comparisons performed; saturating.
- `first_exp` output WIDTH: expected value at the first mismatch.
- `first_got` output WIDTH: observed value at the first mismatch.
- `active` output 1: high while in CHECK.
- `pass` output 1: high when in CHECK or HALT with `chk_count != 0` and `err_count == 0`.

## Operation
- The prediction step at each edge is:
  - `nxt = 0` if `dut_reset`;
  - else `exp ± 1` if `enable` (+ when `up_down=1`, − when `up_down=0`);
  - else `exp` unchanged.
- Arithmetic is modulo 2^WIDTH: 0xFF + 1 → 0x00, and 0x00 − 1 → 0xFF.
- `dut_reset` has priority over `enable`.
- State machine:
  - **IDLE**: no comparisons. On `start`, load `exp_q <= nxt(cnt_in)`, computed from the controls sampled at that edge, and go to CHECK.
  - **CHECK**: every edge:
    - compare `cnt_in` with `exp_q`;
    - increment `chk_count`;
    - set `exp_q <= nxt(exp_q)`.
    - On a mismatch:
      - set `mismatch=1` for the next cycle;
      - increment `err_count`;
      - if `err_count` was 0, capture `first_exp`/`first_got`;
      - if `STOP_ON_ERR=1`, go to HALT.
    - `exp_q` always follows the prediction; it never resyncs to `cnt_in`.
  - **HALT**: comparisons stop; `exp_q`, both counters and the captures hold; `mismatch` stays 0.
- `clear` has priority over `start` and over comparison:
  - from any state, next state is IDLE;
  - `err_count`, `chk_count`, `first_exp`, `first_got` and `mismatch` go to 0;
  - `exp_q` goes to 0.
- `start` while in CHECK or HALT is ignored.
- Both counters saturate at all-ones; `mismatch` keeps pulsing after `err_count` saturates.

## Timing
- After `reset` asserts, all outputs are 0 and the state is IDLE.
- The comparison is combinational on the `cnt_in`/`exp_q` sampled at edge k. Its results appear after edge k:
  - `mismatch` is high in cycle k+1;
  - the counters are updated in cycle k+1.
- Latency from `start` (edge s):
  - the first comparison is at edge s+1;
  - `active=1` from cycle s+1.
- `cnt_in` and the controls must be the same-cycle values that the counter itself samples, with no extra pipeline stage.
- If `reset` is asserted mid-operation, the block returns to IDLE immediately and all statistics are lost.
- If `dut_reset` is asserted mid-CHECK, the prediction goes to 0 at that edge. The counter does the same, so no mismatch results.

## Test plan
- **Reset values**: hold `reset`=0 for 3 cycles, then release → all outputs 0, `active=0`, `pass=0`.
- **Count up**: drive `cnt_in` from a golden up-counter. Pulse `start`, then `enable=1, up_down=1` for 300 cycles → 0xFF→0x00 wraps without error, `err_count=0`, `chk_count=300`, `pass=1`.
- **Count down**: start at 0x00, `up_down=0`, `enable=1` for 10 cycles → `expected=0xF6` after 10 edges, no mismatch.
- **Enable low and dut_reset**: during CHECK at value 0x2A:
  - hold `enable=0` for 5 cycles → `expected` stays 0x2A;
  - pulse `dut_reset` → `expected=0`, still no mismatch.
- **Injected fault**: force `cnt_in=0x13` for exactly one cycle while 0x12 is expected:
  - with `STOP_ON_ERR=0` → one `mismatch` pulse, `err_count=1`, `first_exp=0x12`, `first_got=0x13`, checking continues;
  - with `STOP_ON_ERR=1` → HALT, and the counters freeze.
- **Clear vs start**: assert `clear` and `start` in the same cycle → IDLE, all statistics 0. A `start` one cycle later re-arms the checker.
